// File: rtl/addsub_mp_if.sv
// Operand/result bundle for the multi-precision add/sub engine.
// The master drives the command and operand words; the slave returns results and flags.
interface addsub_mp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             out_valid;
    logic             done;
    logic             sign;
    logic             z;
    logic             c;
    logic             v;

    modport master (
        output start, op, in_valid, a, b,
        input  in_ready, sum, out_valid, done, sign, z, c, v
    );

    modport slave (
        input  start, op, in_valid, a, b,
        output in_ready, sum, out_valid, done, sign, z, c, v
    );
endinterface

// File: rtl/addsub_mp.sv
// Multi-precision add/sub/compare: streams WORDS words LS-first, chains carry internally,
// and reports sign/zero/carry/overflow of the full-width result at the last word.
module addsub_mp #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    addsub_mp_if.slave bus
);
    localparam int            CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_CMP = 2'd2;
    localparam logic [1:0] OP_ADC = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             zacc_q;
    logic             cin_q;
    logic [WIDTH-1:0] sum_q;
    logic             out_valid_q;
    logic             done_q;
    logic             sign_q, z_q, c_q, v_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_d;
    logic [WIDTH-1:0] r_d;
    logic             msb_cin_d;
    logic             zacc_d;

    always_comb begin
        b_eff     = ((op_q == OP_SUB) || (op_q == OP_CMP)) ? ~bus.b : bus.b;
        full_d    = {1'b0, bus.a} + {1'b0, b_eff} + (WIDTH+1)'(cin_q);
        r_d       = full_d[WIDTH-1:0];
        // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
        msb_cin_d = full_d[WIDTH-1] ^ bus.a[WIDTH-1] ^ b_eff[WIDTH-1];
        zacc_d    = zacc_q & (r_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            zacc_q      <= 1'b0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            sign_q      <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        op_q    <= bus.op;
                        cnt_q   <= '0;
                        zacc_q  <= 1'b1;
                        // Carry-in is preset to the first word's value so RUN needs no first-word special case.
                        cin_q   <= (bus.op == OP_ADD) ? 1'b0 :
                                   (bus.op == OP_ADC) ? c_q  : 1'b1;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        cnt_q  <= cnt_q + CW'(1);
                        cin_q  <= full_d[WIDTH];
                        zacc_q <= zacc_d;
                        if (op_q != OP_CMP) begin
                            sum_q       <= r_d;
                            out_valid_q <= 1'b1;
                        end
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            c_q     <= full_d[WIDTH];
                            sign_q  <= r_d[WIDTH-1];
                            v_q     <= msb_cin_d ^ full_d[WIDTH];
                            z_q     <= zacc_d;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.sum       = sum_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.sign      = sign_q;
    assign bus.z         = z_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
endmodule
